// File: rtl/usb_rx_sequencer_if.sv
// Line/DPLL inputs and received-data outputs of the full-speed USB receive sequencer.
// master = line, DPLL and byte consumer side; slave = the sequencer itself.
interface usb_rx_sequencer_if;
  logic       lineP;
  logic       lineN;
  logic       dpllClk12;
  logic       dpllData;
  logic       dpllRst;
  logic       rxActive;
  logic [7:0] rxByte;
  logic       rxByteValid;
  logic       rxEop;
  logic       rxError;

  modport master (
    output lineP, lineN, dpllClk12, dpllData,
    input  dpllRst, rxActive, rxByte, rxByteValid, rxEop, rxError
  );

  modport slave (
    input  lineP, lineN, dpllClk12, dpllData,
    output dpllRst, rxActive, rxByte, rxByteValid, rxEop, rxError
  );
endinterface

// File: rtl/usb_rx_sequencer.sv
// Full-speed USB receive sequencer: DPLL reset control, SYNC match, NRZI decode, bit unstuffing, byte assembly, EOP.
// Optional macro RX_BITSTUFF_ERROR_EN: a decoded 1 where a stuffed bit is expected raises rxError.
module usb_rx_sequencer #(
  parameter int STROBE_TIMEOUT = 16
) (
  input logic               clk48,
  input logic               RST,
  usb_rx_sequencer_if.slave bus
);

  localparam int              TO_W     = $clog2(STROBE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(STROBE_TIMEOUT);
  localparam logic            LINE_K   = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP1,
    S_EOP2,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic            clk12_q;
  logic            sync_last_q, sync_last_d;
  logic [2:0]      sync_run_q, sync_run_d;
  logic [3:0]      sync_cnt_q, sync_cnt_d;
  logic            prev_line_q, prev_line_d;
  logic [2:0]      ones_q, ones_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            j_seen_q, j_seen_d;

  logic            dpll_rst_q, dpll_rst_d;
  logic            rx_active_q, rx_active_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_byte_valid_q, rx_byte_valid_d;
  logic            rx_eop_q, rx_eop_d;
  logic            rx_error_q, rx_error_d;

  logic strobe;
  logic line_k, line_j, line_se0;
  logic dbit;
  logic sync_match;
  logic timeout;
  logic byte_emit;
  logic err_pulse;
  logic eop_pulse;

  assign strobe   = bus.dpllClk12 & ~clk12_q;
  assign line_k   = ~bus.lineP &  bus.lineN;
  assign line_j   =  bus.lineP & ~bus.lineN;
  assign line_se0 = ~bus.lineP & ~bus.lineN;

  always_comb begin
    state_d     = state_q;
    sync_last_d = sync_last_q;
    sync_run_d  = sync_run_q;
    sync_cnt_d  = sync_cnt_q;
    prev_line_d = prev_line_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = '0;
    j_seen_d    = 1'b0;
    dbit        = (bus.dpllData == prev_line_q);
    sync_match  = 1'b0;
    timeout     = 1'b0;
    byte_emit   = 1'b0;
    err_pulse   = 1'b0;
    eop_pulse   = 1'b0;

    // Strobe watchdog: the count only survives in states that depend on the DPLL.
    if (state_q == S_SYNC || state_q == S_DATA) begin
      timeout  = (to_cnt_q == TO_LIMIT);
      to_cnt_d = strobe ? '0 : (timeout ? to_cnt_q : to_cnt_q + 1'b1);
    end

    case (state_q)
      S_IDLE: begin
        sync_run_d = '0;
        sync_cnt_d = '0;
        ones_d     = '0;
        bit_cnt_d  = '0;
        if (line_k) begin
          state_d = S_SYNC;
        end
      end

      S_SYNC: begin
        if (strobe) begin
          sync_cnt_d  = sync_cnt_q + 1'b1;
          sync_last_d = bus.dpllData;
          if (sync_run_q == '0) begin
            sync_run_d = 3'd1;
          end else if (bus.dpllData != sync_last_q) begin
            sync_run_d = (sync_run_q == 3'd7) ? 3'd7 : sync_run_q + 1'b1;
          end else begin
            // Run length counts the first K of the closing KK, so >=5 means >=4 alternations before it.
            sync_run_d = 3'd1;
            sync_match = (bus.dpllData == LINE_K) && (sync_run_q >= 3'd5);
          end
          if (sync_match) begin
            state_d     = S_DATA;
            prev_line_d = LINE_K;
            ones_d      = '0;
            bit_cnt_d   = '0;
          end else if (sync_cnt_q == 4'd11) begin
            state_d   = S_ERR;
            err_pulse = 1'b1;
          end
        end
      end

      S_DATA: begin
        if (strobe) begin
          if (line_se0) begin
            state_d = S_EOP1;
          end else begin
            prev_line_d = bus.dpllData;
            if (ones_q == 3'd6) begin
              ones_d = '0;
`ifdef RX_BITSTUFF_ERROR_EN
              if (dbit) begin
                state_d   = S_ERR;
                err_pulse = 1'b1;
              end
`endif
            end else begin
              ones_d    = dbit ? ones_q + 1'b1 : '0;
              shift_d   = {dbit, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 1'b1;
              byte_emit = (bit_cnt_q == 3'd7);
            end
          end
        end
      end

      S_EOP1: begin
        if (strobe) begin
          if (line_se0) begin
            state_d = S_EOP2;
          end else begin
            state_d   = S_ERR;
            err_pulse = 1'b1;
          end
        end
      end

      S_EOP2: begin
        if (strobe) begin
          if (line_j) begin
            state_d = S_IDLE;
            if (bit_cnt_q == '0) begin
              eop_pulse = 1'b1;
            end else begin
              err_pulse = 1'b1;
            end
          end else begin
            state_d   = S_ERR;
            err_pulse = 1'b1;
          end
        end
      end

      S_ERR: begin
        if (line_j) begin
          if (j_seen_q) begin
            state_d = S_IDLE;
          end else begin
            j_seen_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Timeout wins the transition but does not suppress a byte completed in the same cycle.
    if (timeout) begin
      state_d   = S_ERR;
      err_pulse = 1'b1;
    end

    dpll_rst_d      = (state_d == S_IDLE) || (state_d == S_ERR);
    rx_active_d     = (state_d == S_DATA) || (state_d == S_EOP1) || (state_d == S_EOP2);
    rx_byte_d       = byte_emit ? shift_d : rx_byte_q;
    rx_byte_valid_d = byte_emit;
    rx_eop_d        = eop_pulse;
    rx_error_d      = err_pulse;
  end

  always_ff @(posedge clk48) begin
    if (RST) begin
      state_q         <= S_IDLE;
      clk12_q         <= 1'b0;
      sync_last_q     <= 1'b0;
      sync_run_q      <= '0;
      sync_cnt_q      <= '0;
      prev_line_q     <= LINE_K;
      ones_q          <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      to_cnt_q        <= '0;
      j_seen_q        <= 1'b0;
      dpll_rst_q      <= 1'b1;
      rx_active_q     <= 1'b0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      rx_eop_q        <= 1'b0;
      rx_error_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      clk12_q         <= bus.dpllClk12;
      sync_last_q     <= sync_last_d;
      sync_run_q      <= sync_run_d;
      sync_cnt_q      <= sync_cnt_d;
      prev_line_q     <= prev_line_d;
      ones_q          <= ones_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      to_cnt_q        <= to_cnt_d;
      j_seen_q        <= j_seen_d;
      dpll_rst_q      <= dpll_rst_d;
      rx_active_q     <= rx_active_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      rx_eop_q        <= rx_eop_d;
      rx_error_q      <= rx_error_d;
    end
  end

  assign bus.dpllRst     = dpll_rst_q;
  assign bus.rxActive    = rx_active_q;
  assign bus.rxByte      = rx_byte_q;
  assign bus.rxByteValid = rx_byte_valid_q;
  assign bus.rxEop       = rx_eop_q;
  assign bus.rxError     = rx_error_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Bench for usb_rx_sequencer: packets are built from payload bytes (stuffing + NRZI),
// played on the line, and the emitted bytes/EOP/errors compared with the payload.
module tb_usb_rx_sequencer;

  localparam logic [1:0] SYM_SE0 = 2'b00;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_J   = 2'b10;

  logic clk48 = 1'b0;
  logic RST   = 1'b1;

  usb_rx_sequencer_if bus();

  usb_rx_sequencer #(.STROBE_TIMEOUT(16)) dut (
    .clk48 (clk48),
    .RST   (RST),
    .bus   (bus)
  );

  always #10 clk48 = ~clk48;

  int n_tests = 0;
  int n_fail  = 0;

  // Event recorder
  int         cyc        = 0;
  int         strobe_cyc = -100;
  logic       clk12_prev = 1'b0;
  logic [7:0] byte_q[$];
  int         eop_cnt    = 0;
  int         eop_bad    = 0;
  int         err_cnt    = 0;
  int         byte_late  = 0;
  int         rst_low    = 0;
  logic       act_prev   = 1'b0;

  always @(posedge clk48) begin
    cyc <= cyc + 1;
    if (bus.dpllClk12 && !clk12_prev) strobe_cyc <= cyc + 1;
    clk12_prev <= bus.dpllClk12;
  end

  always @(negedge clk48) begin
    if (!RST) begin
      if (bus.rxByteValid) begin
        byte_q.push_back(bus.rxByte);
        if (strobe_cyc != cyc) byte_late <= byte_late + 1;
      end
      if (bus.rxEop) begin
        eop_cnt <= eop_cnt + 1;
        if (bus.rxActive || !bus.dpllRst || !act_prev) eop_bad <= eop_bad + 1;
      end
      if (bus.rxError) err_cnt <= err_cnt + 1;
      if (!bus.dpllRst) rst_low <= rst_low + 1;
    end
    act_prev <= bus.rxActive;
  end

  // Packet builder state
  logic [1:0] sym_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  int         n_extra;
  logic [6:0] extra_bits;
  logic [1:0] enc_prev;
  int         enc_ones;

  typedef struct {
    string      name;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    int         nextra;
    logic [6:0] extra;
    int         exp_nbytes;
    logic [7:0] e0;
    logic [7:0] e1;
    int         exp_eop;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_sym(input logic [1:0] s);
    @(negedge clk48);
    bus.lineP     = s[1];
    bus.lineN     = s[0];
    bus.dpllData  = s[1];
    bus.dpllClk12 = 1'b1;
    @(negedge clk48);
    @(negedge clk48);
    bus.dpllClk12 = 1'b0;
    @(negedge clk48);
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n && i < sym_q.size(); i++) drive_sym(sym_q[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_sym(SYM_J);
  endtask

  function automatic logic [1:0] flip(input logic [1:0] s);
    return (s == SYM_K) ? SYM_J : SYM_K;
  endfunction

  task automatic push_sync();
    sym_q.delete();
    for (int i = 0; i < 3; i++) begin
      sym_q.push_back(SYM_K);
      sym_q.push_back(SYM_J);
    end
    sym_q.push_back(SYM_K);
    sym_q.push_back(SYM_K);
    enc_prev = SYM_K;
    enc_ones = 0;
  endtask

  // NRZI: 1 = no transition; a 0 is inserted after every six 1s
  task automatic enc_bit(input logic b);
    if (!b) enc_prev = flip(enc_prev);
    sym_q.push_back(enc_prev);
    enc_ones = b ? enc_ones + 1 : 0;
    if (enc_ones == 6) begin
      enc_prev = flip(enc_prev);
      sym_q.push_back(enc_prev);
      enc_ones = 0;
    end
  endtask

  task automatic encode();
    logic [7:0] b;
    push_sync();
    foreach (pay_q[i]) begin
      b = pay_q[i];
      for (int j = 0; j < 8; j++) enc_bit(b[j]);
    end
    for (int j = 0; j < n_extra; j++) enc_bit(extra_bits[j]);
    sym_q.push_back(SYM_SE0);
    sym_q.push_back(SYM_SE0);
    sym_q.push_back(SYM_J);
  endtask

  task automatic run_pkt(input string name, input int exp_eop, input int exp_err);
    int b0 = byte_q.size();
    int e0 = eop_cnt;
    int eb = eop_bad;
    int r0 = err_cnt;
    int l0 = byte_late;
    encode();
    play(sym_q.size());
    idle(3);
    check({name, "_nbytes"}, byte_q.size() - b0, exp_q.size());
    foreach (exp_q[i]) begin
      if (b0 + i < byte_q.size()) check({name, "_byte"}, byte_q[b0 + i], exp_q[i]);
    end
    check({name, "_eop"}, eop_cnt - e0, exp_eop);
    check({name, "_eop_timing"}, eop_bad - eb, 0);
    check({name, "_err"}, err_cnt - r0, exp_err);
    check({name, "_byte_timing"}, byte_late - l0, 0);
    $display("[TB] packet %s: %0d payload bytes, %0d extra bits done", name, pay_q.size(), n_extra);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int b0, e0, r0, l0, rl0, dt;
    logic found;

    vecs[0] = '{"a5_3c",   2, 8'hA5, 8'h3C, 0, 7'h00,    2, 8'hA5, 8'h3C, 1, 0};
    vecs[1] = '{"ff_stuff",1, 8'hFF, 8'h00, 0, 7'h00,    1, 8'hFF, 8'h00, 1, 0};
    vecs[2] = '{"3bits",   0, 8'h00, 8'h00, 3, 7'b101,   0, 8'h00, 8'h00, 0, 1};
    vecs[3] = '{"zero",    1, 8'h00, 8'h00, 0, 7'h00,    1, 8'h00, 8'h00, 1, 0};
    vecs[4] = '{"7e_81",   2, 8'h7E, 8'h81, 0, 7'h00,    2, 8'h7E, 8'h81, 1, 0};
    vecs[5] = '{"5a_part", 1, 8'h5A, 8'h00, 5, 7'b10110, 1, 8'h5A, 8'h00, 0, 1};

    bus.lineP     = 1'b1;
    bus.lineN     = 1'b0;
    bus.dpllData  = 1'b1;
    bus.dpllClk12 = 1'b0;

    // Reset values
    repeat (3) @(negedge clk48);
    check("rst_dpllRst", bus.dpllRst, 1);
    check("rst_rxActive", bus.rxActive, 0);
    check("rst_rxByte", bus.rxByte, 8'h00);
    check("rst_rxByteValid", bus.rxByteValid, 0);
    check("rst_rxEop", bus.rxEop, 0);
    check("rst_rxError", bus.rxError, 0);
    RST = 1'b0;
    $display("[TB] reset values done");

    // Idle J for 100 cycles, then a K releases the DPLL one cycle later
    b0 = byte_q.size(); e0 = eop_cnt; r0 = err_cnt; rl0 = rst_low;
    idle(25);
    check("idle_dpllRst_low_cycles", rst_low - rl0, 0);
    check("idle_pulses", (byte_q.size() - b0) + (eop_cnt - e0) + (err_cnt - r0), 0);
    check("k_before_dpllRst", bus.dpllRst, 1);
    bus.lineP = 1'b0;
    bus.lineN = 1'b1;
    @(negedge clk48);
    check("k_dpllRst_fall", bus.dpllRst, 0);
    bus.lineP = 1'b1;
    bus.lineN = 1'b0;
    r0 = err_cnt;
    repeat (40) @(negedge clk48);
    check("k_no_strobe_err", err_cnt - r0, 1);
    check("k_back_idle", bus.dpllRst, 1);
    $display("[TB] idle/K release done");

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      pay_q.delete();
      exp_q.delete();
      if (vecs[v].nbytes > 0) pay_q.push_back(vecs[v].b0);
      if (vecs[v].nbytes > 1) pay_q.push_back(vecs[v].b1);
      if (vecs[v].exp_nbytes > 0) exp_q.push_back(vecs[v].e0);
      if (vecs[v].exp_nbytes > 1) exp_q.push_back(vecs[v].e1);
      n_extra    = vecs[v].nextra;
      extra_bits = vecs[v].extra;
      run_pkt(vecs[v].name, vecs[v].exp_eop, vecs[v].exp_err);
    end

    // Six 1s followed by a 1 where the stuffed 0 belongs
    b0 = byte_q.size(); e0 = eop_cnt; r0 = err_cnt;
    push_sync();
`ifdef RX_BITSTUFF_ERROR_EN
    for (int i = 0; i < 7; i++) sym_q.push_back(SYM_K);
    play(sym_q.size());
    idle(4);
    check("stufferr_err", err_cnt - r0, 1);
    check("stufferr_nbytes", byte_q.size() - b0, 0);
    check("stufferr_eop", eop_cnt - e0, 0);
    check("stufferr_idle", bus.dpllRst, 1);
`else
    for (int i = 0; i < 9; i++) sym_q.push_back(SYM_K);
    sym_q.push_back(SYM_SE0);
    sym_q.push_back(SYM_SE0);
    sym_q.push_back(SYM_J);
    play(sym_q.size());
    idle(3);
    check("nostuff_err", err_cnt - r0, 0);
    check("nostuff_nbytes", byte_q.size() - b0, 1);
    if (byte_q.size() > b0) check("nostuff_byte", byte_q[b0], 8'hFF);
    check("nostuff_eop", eop_cnt - e0, 1);
`endif
    $display("[TB] missing stuff bit done");

    // Randomized packets
    for (int k = 0; k < 25; k++) begin
      pay_q.delete();
      exp_q.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) begin
        logic [7:0] rb;
        rb = 8'($urandom);
        pay_q.push_back(rb);
        exp_q.push_back(rb);
      end
      n_extra    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      extra_bits = 7'($urandom);
      run_pkt("rand", (n_extra == 0) ? 1 : 0, (n_extra != 0) ? 1 : 0);
    end
    n_extra = 0;

    // Strobe timeout after SYNC
    r0 = err_cnt;
    pay_q.delete();
    encode();
    play(8);
    found = 1'b0;
    dt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk48);
      if (bus.rxError && !found) begin
        found = 1'b1;
        dt = cyc - strobe_cyc;
      end
    end
    check("timeout_seen", found, 1);
    check("timeout_latency_16_to_18", (dt >= 16 && dt <= 18) ? 1 : 0, 1);
    check("timeout_err_count", err_cnt - r0, 1);
    idle(3);
    check("timeout_back_idle", bus.dpllRst, 1);
    $display("[TB] timeout done, latency %0d cycles", dt);

    // RST mid-packet
    pay_q.delete();
    pay_q.push_back(8'h5A);
    pay_q.push_back(8'hC3);
    pay_q.push_back(8'h99);
    encode();
    play(30);
    check("midrst_pre_active", bus.rxActive, 1);
    RST          = 1'b1;
    bus.lineP    = 1'b1;
    bus.lineN    = 1'b0;
    bus.dpllData = 1'b1;
    @(negedge clk48);
    check("midrst_dpllRst", bus.dpllRst, 1);
    check("midrst_rxActive", bus.rxActive, 0);
    check("midrst_rxByte", bus.rxByte, 8'h00);
    check("midrst_rxByteValid", bus.rxByteValid, 0);
    check("midrst_rxEop", bus.rxEop, 0);
    check("midrst_rxError", bus.rxError, 0);
    RST = 1'b0;
    b0 = byte_q.size(); e0 = eop_cnt; r0 = err_cnt; l0 = rst_low;
    idle(10);
    check("midrst_no_pulses", (byte_q.size() - b0) + (eop_cnt - e0) + (err_cnt - r0), 0);
    check("midrst_dpll_held", rst_low - l0, 0);
    $display("[TB] mid-packet reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
